// File: rtl/posit_pkg.sv
// Shared types for the posit unit: formats, operations, status flags and
// the FMA arbiter state encoding.
package posit_pkg;

  typedef enum logic [1:0] {
    POSIT32_ES2,
    POSIT16_ES1,
    POSIT8_ES0
  } posit_format_e;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX, CMP, CLASSIFY, F2I, I2F
  } operation_e;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_e;

  localparam int unsigned MAX_WIDTH = 32;

  function automatic int unsigned posit_width(posit_format_e fmt);
    case (fmt)
      POSIT16_ES1: return 16;
      POSIT8_ES0:  return 8;
      default:     return 32;
    endcase
  endfunction

  // Not-a-Real: sign bit set, every other bit clear.
  function automatic logic [MAX_WIDTH-1:0] nar(int unsigned width);
    nar = '0;
    nar[width-1] = 1'b1;
  endfunction

  function automatic logic fma_supported(operation_e op);
    return (op == FMADD) || (op == FNMSUB) || (op == ADD) || (op == MUL);
  endfunction

endpackage

// File: rtl/posit_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module posit_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any
);

  int unsigned idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr) + i) % NUM_REQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/posit_fma_arbiter.sv
// Shares one posit FMA between NUM_REQ requesters: round-robin grant, one
// operation in flight, unsupported ops answered locally with NaR/NV.
module posit_fma_arbiter
  import posit_pkg::*;
#(
  parameter posit_format_e pFormat = posit_format_e'(0),
  parameter int unsigned   NUM_REQ = 4,
  localparam int unsigned  WIDTH   = posit_width(pFormat),
  localparam int unsigned  ID_W    = $clog2(NUM_REQ)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  input  logic [NUM_REQ-1:0][2:0][WIDTH-1:0]  req_operands_i,
  input  operation_e [NUM_REQ-1:0]            req_op_i,
  input  logic [NUM_REQ-1:0]                  req_op_mod_i,
  output logic [NUM_REQ-1:0]                  rsp_valid_o,
  input  logic [NUM_REQ-1:0]                  rsp_ready_i,
  output logic [WIDTH-1:0]                    rsp_result_o,
  output status_t                             rsp_status_o,
  output logic [2:0][WIDTH-1:0]               fma_operands_o,
  output operation_e                          fma_op_o,
  output logic                                fma_op_mod_o,
  output logic                                fma_tag_o,
  output logic                                fma_in_valid_o,
  input  logic                                fma_in_ready_i,
  input  logic [WIDTH-1:0]                    fma_result_i,
  input  status_t                             fma_status_i,
  input  logic                                fma_tag_i,
  input  logic                                fma_out_valid_i,
  output logic                                fma_out_ready_o,
  output logic                                fma_flush_o,
  output logic                                busy_o,
  output logic [31:0]                         ops_count_o
);

  localparam logic [WIDTH-1:0] NAR = WIDTH'(nar(WIDTH));

  arb_state_e               state_q, state_d;
  logic [ID_W-1:0]          rr_ptr_q, id_q, grant_id;
  logic [NUM_REQ-1:0]       grant;
  logic                     any;
  logic [2:0][WIDTH-1:0]    operands_q;
  operation_e               op_q;
  logic                     op_mod_q;
  logic [WIDTH-1:0]         result_q;
  status_t                  status_q;
  logic [31:0]              ops_count_q;
  logic                     fma_fire;

  posit_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req      (req_valid_i),
    .ptr      (rr_ptr_q),
    .grant    (grant),
    .grant_id (grant_id),
    .any      (any)
  );

  assign fma_fire = fma_in_ready_i & fma_out_valid_i & fma_tag_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    req_ready_o     = '0;
    rsp_valid_o     = '0;
    fma_in_valid_o  = 1'b0;
    fma_out_ready_o = 1'b0;
    fma_tag_o       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush_i) req_ready_o = grant;
        if (any) state_d = fma_supported(req_op_i[grant_id]) ? ISSUE : RESP;
      end
      ISSUE: begin
        fma_in_valid_o  = 1'b1;
        fma_out_ready_o = 1'b1;
        fma_tag_o       = 1'b1;
        if (fma_fire) state_d = RESP;
      end
      RESP: begin
        rsp_valid_o[id_q] = 1'b1;
        if (rsp_ready_i[id_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  // Datapath updates are suppressed on flush so a dropped op leaves no trace.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q    <= '0;
      id_q        <= '0;
      operands_q  <= '0;
      op_q        <= operation_e'(0);
      op_mod_q    <= 1'b0;
      result_q    <= '0;
      status_q    <= '0;
      ops_count_q <= '0;
    end else if (!flush_i) begin
      case (state_q)
        IDLE: if (any) begin
          operands_q <= req_operands_i[grant_id];
          op_q       <= req_op_i[grant_id];
          op_mod_q   <= req_op_mod_i[grant_id];
          id_q       <= grant_id;
          if (!fma_supported(req_op_i[grant_id])) begin
            result_q <= NAR;
            status_q <= status_t'{NV: 1'b1, default: 1'b0};
          end
        end
        ISSUE: if (fma_fire) begin
          result_q <= fma_result_i;
          status_q <= fma_status_i;
        end
        RESP: if (rsp_ready_i[id_q]) begin
          ops_count_q <= ops_count_q + 32'd1;
          rr_ptr_q    <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign fma_operands_o = operands_q;
  assign fma_op_o       = op_q;
  assign fma_op_mod_o   = op_mod_q;
  assign fma_flush_o    = flush_i;
  assign rsp_result_o   = result_q;
  assign rsp_status_o   = status_q;
  assign busy_o         = (state_q != IDLE);
  assign ops_count_o    = ops_count_q;

endmodule

// File: tb/tb_posit_fma_arbiter.sv
// Directed bench for posit_fma_arbiter with a combinational stub FMA.
module tb_posit_fma_arbiter;
  import posit_pkg::*;

  localparam int unsigned W = 32;
  localparam int unsigned N = 4;

  logic                      clk = 1'b0;
  logic                      rst, flush;
  logic [N-1:0]              req_valid, req_ready, req_op_mod, rsp_valid, rsp_ready;
  logic [N-1:0][2:0][W-1:0]  req_operands;
  operation_e [N-1:0]        req_op;
  logic [W-1:0]              rsp_result, fma_result;
  status_t                   rsp_status, fma_status;
  logic [2:0][W-1:0]         fma_operands;
  operation_e                fma_op;
  logic                      fma_op_mod, fma_tag_out, fma_in_valid, fma_in_ready;
  logic                      fma_tag_in, fma_out_valid, fma_out_ready, fma_flush, busy;
  logic [31:0]               ops_count;
  logic                      fma_stall;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  posit_fma_arbiter #(.pFormat(POSIT32_ES2), .NUM_REQ(N)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_operands_i(req_operands),
    .req_op_i(req_op), .req_op_mod_i(req_op_mod),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_status_o(rsp_status),
    .fma_operands_o(fma_operands), .fma_op_o(fma_op), .fma_op_mod_o(fma_op_mod),
    .fma_tag_o(fma_tag_out), .fma_in_valid_o(fma_in_valid), .fma_in_ready_i(fma_in_ready),
    .fma_result_i(fma_result), .fma_status_i(fma_status), .fma_tag_i(fma_tag_in),
    .fma_out_valid_i(fma_out_valid), .fma_out_ready_o(fma_out_ready),
    .fma_flush_o(fma_flush), .busy_o(busy), .ops_count_o(ops_count)
  );

  // Stub FMA: knows 1*1+1=2 in posit32/es2; otherwise returns A+B+C as a marker.
  assign fma_in_ready  = 1'b1;
  assign fma_out_valid = fma_in_valid & ~fma_stall;
  assign fma_tag_in    = fma_tag_out;
  assign fma_status    = '0;
  always_comb begin
    fma_result = fma_operands[0] + fma_operands[1] + fma_operands[2];
    if (fma_op == FMADD && fma_operands[0] == 32'h4000_0000 &&
        fma_operands[1] == 32'h4000_0000 && fma_operands[2] == 32'h4000_0000)
      fma_result = 32'h4800_0000;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    settle();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; fma_stall = 1'b0;
    req_valid = '0; req_op_mod = '0; rsp_ready = '0;
    for (int i = 0; i < N; i++) begin
      req_operands[i] = {W'(32'h100), W'(32'h10), W'(i + 1)};
      req_op[i] = ADD;
    end
    cyc(); cyc();
    rst = 1'b0;
    settle();

    check("rst_busy", 64'(busy), 64'd0);
    check("rst_count", 64'(ops_count), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_fma_valid", 64'(fma_in_valid), 64'd0);
    check("rst_result", 64'(rsp_result), 64'd0);

    // Single FMADD 1*1+1 from req0
    req_operands[0] = {3{32'h4000_0000}};
    req_op[0] = FMADD;
    req_valid = 4'b0001;
    settle();
    check("t1_req_ready", 64'(req_ready), 64'b0001);
    cyc();
    req_valid = '0;
    rsp_ready = 4'b1111;
    settle();
    check("t1_fma_valid", 64'(fma_in_valid), 64'd1);
    check("t1_fma_tag", 64'(fma_tag_out), 64'd1);
    check("t1_fma_opA", 64'(fma_operands[0]), 64'h4000_0000);
    check("t1_fma_op", 64'(fma_op), 64'(FMADD));
    cyc();
    check("t1_rsp_valid", 64'(rsp_valid), 64'b0001);
    check("t1_result", 64'(rsp_result), 64'h4800_0000);
    check("t1_nv", 64'(rsp_status.NV), 64'd0);
    cyc();
    check("t1_count", 64'(ops_count), 64'd1);
    check("t1_idle", 64'(busy), 64'd0);

    // Round-robin fairness from a fresh reset
    do_reset();
    req_operands[0] = {W'(32'h100), W'(32'h10), W'(32'h1)};
    req_op[0] = ADD;
    req_valid = 4'b1111;
    rsp_ready = 4'b1111;
    settle();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t2_grant%0d", k), 64'(req_ready), 64'(4'b0001 << (k % 4)));
      cyc();
      check($sformatf("t2_noready%0d", k), 64'(req_ready), 64'd0);
      cyc();
      check($sformatf("t2_rsp%0d", k), 64'(rsp_valid), 64'(4'b0001 << (k % 4)));
      check($sformatf("t2_res%0d", k), 64'(rsp_result), 64'(32'h111 + (k % 4)));
      cyc();
    end
    check("t2_count", 64'(ops_count), 64'd5);

    // Unsupported op from req2 (rr_ptr is now 1)
    req_valid = 4'b0100;
    req_op[2] = DIV;
    settle();
    check("t3_req_ready", 64'(req_ready), 64'b0100);
    cyc();
    req_valid = '0;
    settle();
    check("t3_rsp_valid", 64'(rsp_valid), 64'b0100);
    check("t3_fma_valid", 64'(fma_in_valid), 64'd0);
    check("t3_result", 64'(rsp_result), 64'h8000_0000);
    check("t3_status", 64'(rsp_status), 64'b10000);
    cyc();
    check("t3_count", 64'(ops_count), 64'd6);
    req_op[2] = ADD;

    // Backpressure: rr_ptr=3, only req1 valid; others' rsp_ready must be ignored
    req_operands[1] = {3{32'h4000_0000}};
    req_op[1] = FMADD;
    req_valid = 4'b0010;
    rsp_ready = 4'b1101;
    settle();
    check("t4_req_ready", 64'(req_ready), 64'b0010);
    cyc();
    req_valid = 4'b1111;
    cyc();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t4_hold_valid%0d", k), 64'(rsp_valid), 64'b0010);
      check($sformatf("t4_hold_res%0d", k), 64'(rsp_result), 64'h4800_0000);
      check($sformatf("t4_hold_rdy%0d", k), 64'(req_ready), 64'd0);
      check($sformatf("t4_hold_fma%0d", k), 64'(fma_in_valid), 64'd0);
      cyc();
    end
    rsp_ready = 4'b0010;
    settle();
    cyc();
    check("t4_count", 64'(ops_count), 64'd7);
    check("t4_next_grant", 64'(req_ready), 64'b0100);

    // Flush during ISSUE: rr_ptr=2, req2 wins
    rsp_ready = 4'b1111;
    fma_stall = 1'b1;
    req_valid = 4'b0100;
    cyc();
    req_valid = '0;
    settle();
    check("t5_issue", 64'(fma_in_valid), 64'd1);
    flush = 1'b1;
    settle();
    check("t5_fma_flush", 64'(fma_flush), 64'd1);
    cyc();
    flush = 1'b0;
    fma_stall = 1'b0;
    settle();
    check("t5_idle", 64'(busy), 64'd0);
    check("t5_no_rsp", 64'(rsp_valid), 64'd0);
    check("t5_count", 64'(ops_count), 64'd7);
    req_valid = 4'b1111;
    settle();
    check("t5_ptr_kept", 64'(req_ready), 64'b0100);

    // Reset while in RESP
    rsp_ready = '0;
    cyc();
    cyc();
    check("t6_in_resp", 64'(rsp_valid), 64'b0100);
    req_valid = '0;
    do_reset();
    check("t6_rsp_valid", 64'(rsp_valid), 64'd0);
    check("t6_req_ready", 64'(req_ready), 64'd0);
    check("t6_fma_valid", 64'(fma_in_valid), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_count", 64'(ops_count), 64'd0);
    req_valid = 4'b1111;
    settle();
    check("t6_grant0", 64'(req_ready), 64'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
